// File: rtl/icfo_ctrl.sv
// Sequencer for the integer-CFO estimator: enables it for one window of strobes,
// waits for a fresh result edge (or times out), and latches the integer offset.
module icfo_ctrl #(
  parameter int SYM_LEN = 256,
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       stb_i,
  output logic       est_ena_o,
  output logic [7:0] est_cnt_o,
  input  logic       est_val_i,
  input  logic [2:0] est_ifoff_i,
  output logic [2:0] ifoff_o,
  output logic       ifoff_val_o,
  output logic       busy_o,
  output logic       err_o
);

  // state  | meaning
  // S_IDLE | estimator disabled, waiting for start_i
  // S_RUN  | estimator enabled, counting input strobes
  // S_WAIT | window complete, waiting for a result edge or timeout
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;

  localparam logic [7:0] CNT_LAST  = 8'(SYM_LEN - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       val_d;
  logic [7:0] wait_cnt;
  logic       val_rise;

  // Only a fresh rising edge counts, so a level left high by the previous run is ignored.
  assign val_rise = est_val_i & ~val_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      est_ena_o   <= 1'b0;
      est_cnt_o   <= '0;
      ifoff_o     <= '0;
      ifoff_val_o <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      val_d       <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      val_d       <= est_val_i;
      ifoff_val_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state     <= S_RUN;
            est_ena_o <= 1'b1;
            est_cnt_o <= '0;
            busy_o    <= 1'b1;
            err_o     <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort_i) begin
            state     <= S_IDLE;
            est_ena_o <= 1'b0;
            est_cnt_o <= '0;
            busy_o    <= 1'b0;
          end else if (stb_i) begin
            if (est_cnt_o == CNT_LAST) begin
              state    <= S_WAIT;
              wait_cnt <= '0;
            end else begin
              est_cnt_o <= est_cnt_o + 8'd1;
            end
          end
        end
        S_WAIT: begin
          if (abort_i || val_rise || wait_cnt == WAIT_LAST) begin
            state     <= S_IDLE;
            est_ena_o <= 1'b0;
            est_cnt_o <= '0;
            busy_o    <= 1'b0;
            wait_cnt  <= '0;
            // A result on the timeout cycle still wins; abort beats both.
            if (!abort_i) begin
              if (val_rise) begin
                ifoff_o     <= est_ifoff_i;
                ifoff_val_o <= 1'b1;
              end else begin
                err_o <= 1'b1;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          est_ena_o <= 1'b0;
          est_cnt_o <= '0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icfo_ctrl.sv
// Directed bench for icfo_ctrl: a table of full estimation runs plus
// hand-written sequences for start-in-RUN, abort in IDLE and reset mid-RUN.
module tb_icfo_ctrl;

  localparam int SYM_LEN = 256;
  localparam int TIMEOUT = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, abort_i, stb_i, est_val_i;
  logic [2:0] est_ifoff_i;
  logic       est_ena_o, ifoff_val_o, busy_o, err_o;
  logic [7:0] est_cnt_o;
  logic [2:0] ifoff_o;

  int checks = 0;
  int errors = 0;

  icfo_ctrl #(.SYM_LEN(SYM_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .stb_i(stb_i),
    .est_ena_o(est_ena_o), .est_cnt_o(est_cnt_o), .est_val_i(est_val_i),
    .est_ifoff_i(est_ifoff_i), .ifoff_o(ifoff_o), .ifoff_val_o(ifoff_val_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // gap: cycles between strobes; dly: WAIT cycle of the est_val_i rise (0 = never)
  typedef struct {
    int         gap;
    int         dly;
    bit         stale;
    bit         abort_rise;
    logic [2:0] ifoff;
    logic [2:0] exp_ifoff;
    bit         exp_pulse;
    bit         exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_busy"}, busy_o, 0);
    chk({name, "_ena"}, est_ena_o, 0);
    chk({name, "_cnt"}, est_cnt_o, 0);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("start_busy", busy_o, 1);
    chk("start_ena", est_ena_o, 1);
    chk("start_cnt", est_cnt_o, 0);
    chk("start_err_clr", err_o, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int exp_cnt;
    est_val_i   = v.stale;
    est_ifoff_i = v.ifoff;
    step();
    do_start();
    exp_cnt = 0;
    for (int i = 0; i < SYM_LEN; i++) begin
      if (i > 0)
        for (int j = 1; j < v.gap; j++) begin
          step();
          chk("cnt_hold", est_cnt_o, exp_cnt);
        end
      stb_i = 1'b1;
      step();
      stb_i = 1'b0;
      exp_cnt = (i + 1 > SYM_LEN - 1) ? SYM_LEN - 1 : i + 1;
      chk("cnt_strobe", est_cnt_o, exp_cnt);
    end
    chk("wait_busy", busy_o, 1);
    chk("wait_ena", est_ena_o, 1);
    if (v.dly == 0) begin
      for (int k = 1; k < TIMEOUT; k++) begin
        step();
        chk("to_pending_busy", busy_o, 1);
        chk("to_pending_err", err_o, 0);
        chk("to_pending_pulse", ifoff_val_o, 0);
        chk("to_pending_cnt", est_cnt_o, SYM_LEN - 1);
      end
      step();
      chk("to_err", err_o, v.exp_err);
      chk("to_pulse", ifoff_val_o, 0);
      chk("to_ifoff", ifoff_o, v.exp_ifoff);
      chk_idle("to_idle");
    end else begin
      for (int k = 1; k < v.dly; k++) begin
        step();
        chk("res_pending_busy", busy_o, 1);
        chk("res_pending_pulse", ifoff_val_o, 0);
      end
      est_val_i = 1'b1;
      abort_i   = v.abort_rise;
      step();
      abort_i = 1'b0;
      chk("res_ifoff", ifoff_o, v.exp_ifoff);
      chk("res_pulse", ifoff_val_o, v.exp_pulse);
      chk("res_err", err_o, v.exp_err);
      chk_idle("res_idle");
      step();
      chk("res_pulse_end", ifoff_val_o, 0);
      chk("res_ifoff_hold", ifoff_o, v.exp_ifoff);
    end
  endtask

  initial begin
    // nominal, rise 10 cycles into WAIT
    vecs[0] = '{gap: 1, dly: 10, stale: 0, abort_rise: 0, ifoff: 3'd5, exp_ifoff: 3'd5, exp_pulse: 1, exp_err: 0};
    // gapped strobes then timeout: ifoff keeps 5
    vecs[1] = '{gap: 3, dly: 0,  stale: 0, abort_rise: 0, ifoff: 3'd2, exp_ifoff: 3'd5, exp_pulse: 0, exp_err: 1};
    // rise on the timeout cycle: result wins
    vecs[2] = '{gap: 1, dly: 32, stale: 0, abort_rise: 0, ifoff: 3'd3, exp_ifoff: 3'd3, exp_pulse: 1, exp_err: 0};
    // stale level held through the run: timeout
    vecs[3] = '{gap: 1, dly: 0,  stale: 1, abort_rise: 0, ifoff: 3'd1, exp_ifoff: 3'd3, exp_pulse: 0, exp_err: 1};
    // abort on the same cycle as the rise
    vecs[4] = '{gap: 1, dly: 4,  stale: 0, abort_rise: 1, ifoff: 3'd6, exp_ifoff: 3'd3, exp_pulse: 0, exp_err: 0};
    // rise on the first WAIT cycle
    vecs[5] = '{gap: 2, dly: 1,  stale: 0, abort_rise: 0, ifoff: 3'd7, exp_ifoff: 3'd7, exp_pulse: 1, exp_err: 0};

    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; stb_i = 1'b0;
    est_val_i = 1'b0; est_ifoff_i = 3'd0;
    step();
    step();
    chk_idle("reset");
    chk("reset_ifoff", ifoff_o, 0);
    chk("reset_pulse", ifoff_val_o, 0);
    chk("reset_err", err_o, 0);
    rst = 1'b0;

    // abort in IDLE does nothing
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk_idle("idle_abort");

    for (int n = 0; n < 6; n++) run_vec(vecs[n]);

    // start_i in RUN is ignored, then abort returns to IDLE
    est_val_i = 1'b0;
    do_start();
    for (int i = 0; i < 50; i++) begin
      stb_i = 1'b1;
      step();
    end
    stb_i = 1'b0;
    chk("run_cnt50", est_cnt_o, 50);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("run_start_ignored", est_cnt_o, 50);
    chk("run_start_busy", busy_o, 1);
    abort_i = 1'b1;
    start_i = 1'b1;
    step();
    abort_i = 1'b0;
    start_i = 1'b0;
    chk_idle("run_abort");
    chk("run_abort_ifoff", ifoff_o, 7);
    chk("run_abort_pulse", ifoff_val_o, 0);

    // reset mid-RUN at count 100 with every other input asserted
    do_start();
    for (int i = 0; i < 100; i++) begin
      stb_i = 1'b1;
      step();
    end
    stb_i = 1'b0;
    chk("pre_rst_cnt", est_cnt_o, 100);
    rst = 1'b1; start_i = 1'b1; abort_i = 1'b1; stb_i = 1'b1; est_val_i = 1'b1;
    step();
    rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; stb_i = 1'b0; est_val_i = 1'b0;
    chk_idle("mid_rst");
    chk("mid_rst_ifoff", ifoff_o, 0);
    chk("mid_rst_pulse", ifoff_val_o, 0);
    chk("mid_rst_err", err_o, 0);
    do_start();
    for (int i = 0; i < 3; i++) begin
      stb_i = 1'b1;
      step();
    end
    stb_i = 1'b0;
    chk("post_rst_cnt", est_cnt_o, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
